clk_div_prog: RTL and testbench
===============================

CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the divisor width in bits.
REQ-002 The block SHALL have port clk  input  1  system clock; all logic is clocked on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port div_val  input  WIDTH  requested divide ratio N, unsigned.
REQ-005 The block SHALL have port div_load  input  1  div_val is captured on any rising clk edge where this is high.
REQ-006 The block SHALL have port div_busy  output  1  a captured divisor is pending and not yet applied.
REQ-007 The block SHALL have port clk_out  output  1  divided clock, driven from a flop.
REQ-008 The block SHALL have port tick  output  1  one-cycle pulse coincident with each rising edge of clk_out.

Function
REQ-009 The block SHALL have two states: IDLE (no valid divisor, clk_out low) and RUN (dividing by active divisor A).
REQ-010 A divisor value N SHALL be valid when N>=2; values 0 and 1 SHALL mean "disable".
REQ-011 In RUN, counter cnt SHALL step 0,1,...,A-1,0 once per clk cycle.
REQ-012 In RUN, clk_out SHALL be high when cnt < ceil(A/2) and low otherwise; even A gives 50% duty; odd A is high one cycle longer than low.
REQ-013 tick SHALL be high exactly in the cycles where cnt==0 in RUN; tick SHALL be low in IDLE.
REQ-014 In IDLE, a load with valid N SHALL enter RUN on the next edge with A=N, cnt=0, clk_out=1, tick=1 (latency 1 cycle); div_busy SHALL stay low.
REQ-015 In IDLE, a load with N<2 SHALL be ignored.
REQ-016 In RUN, a load SHALL store N in a pending register and set div_busy on the next edge; A SHALL NOT change mid-period.
REQ-017 The pending value SHALL be applied at the wrap edge (cnt A-1 -> 0); div_busy SHALL clear on that same edge.
REQ-018 If the pending value is valid, the new period SHALL start with cnt=0, clk_out=1, tick=1 using the new A.
REQ-019 If the pending value is <2, the wrap edge SHALL go to IDLE with clk_out=0, tick=0; no runt pulse.
REQ-020 A load while div_busy is high SHALL overwrite the pending value; last load wins.
REQ-021 A load in the cycle where cnt==A-1 SHALL take effect at that same wrap edge (bypass); div_busy SHALL remain low.
REQ-022 No high or low phase of clk_out SHALL ever be shorter than floor(min(A_old,A_new)/2) cycles.

Reset
REQ-023 Assertion of rst (low) SHALL immediately force state IDLE, cnt=0, A=0, pending=0, div_busy=0, clk_out=0, tick=0.
REQ-024 Reset mid-period SHALL discard active and pending divisors; after release, the block SHALL wait in IDLE for a new load.
REQ-025 Deassertion of rst SHALL be seen synchronously by the flops; the first possible clk_out edge SHALL be one cycle after the first sampled load.

Structure
REQ-026 The shared package clk_div_pkg SHALL hold the WIDTH default, MIN_DIV=2 and the IDLE/RUN state encoding.
REQ-027 The block SHALL be a single module with no sub-module; cnt, A, pending and the state register SHALL be local to it.
REQ-028 The counter and compare logic SHALL be WIDTH bits wide with no overflow at N=2^WIDTH-1.

Verification
REQ-029 Reset, then load N=4 -> clk_out pattern 1100 repeating from the next cycle; tick every 4th cycle; div_busy=0.
REQ-030 Run at N=5 -> clk_out high 3, low 2 cycles; tick period 5.
REQ-031 Run at N=4, load N=6 at cnt=1 -> div_busy=1 until the wrap; current period completes as 1100, then 111000.
REQ-032 Run at N=8, load 3 then 10 while busy -> 10 is applied at the wrap and 3 is never seen; load at cnt=7 applies with div_busy low.
REQ-033 Run at N=6, load N=0 -> current period finishes, then clk_out=0 and tick=0 hold in IDLE; load N=1 in IDLE -> ignored.
REQ-034 Assert rst at cnt=2 with div_busy=1 -> all outputs 0 immediately with no clk edge needed; block stays idle after release until loaded.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable clock divider: default width,
// smallest usable divide ratio and the controller state encoding.
package clk_div_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int MIN_DIV   = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/clk_div_prog.sv
// Programmable integer clock divider with glitch-free divisor changes applied
// only on period boundaries; clk_out and tick come straight from flops.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] div_val,
    input  logic             div_load,
    output logic             div_busy,
    output logic             clk_out,
    output logic             tick,
    output state_t           state_dbg
);

    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] MIN_N = WIDTH'(MIN_DIV);

    state_t           state, state_n;
    logic [WIDTH-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] a_q, a_n;
    logic [WIDTH-1:0] pend, pend_n;
    logic             busy_n;
    logic             clk_n;
    logic             tick_n;

    logic [WIDTH-1:0] half;
    logic [WIDTH-1:0] cnt_inc;
    logic [WIDTH-1:0] eff;
    logic             wrap;

    // ceil(A/2) built without an extra carry bit so A = 2^WIDTH-1 is safe.
    assign half    = (a_q >> 1) + {{(WIDTH-1){1'b0}}, a_q[0]};
    assign cnt_inc = cnt + ONE;
    assign wrap    = (cnt == a_q - ONE);
    // Divisor for the next period: a same-cycle load bypasses the pending slot.
    assign eff     = div_load ? div_val : (div_busy ? pend : a_q);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        a_n     = a_q;
        pend_n  = pend;
        busy_n  = div_busy;
        clk_n   = clk_out;
        tick_n  = 1'b0;
        case (state)
            IDLE: begin
                clk_n = 1'b0;
                if (div_load && (div_val >= MIN_N)) begin
                    state_n = RUN;
                    a_n     = div_val;
                    cnt_n   = '0;
                    clk_n   = 1'b1;
                    tick_n  = 1'b1;
                end
            end
            RUN: begin
                if (wrap) begin
                    busy_n = 1'b0;
                    pend_n = '0;
                    cnt_n  = '0;
                    if (eff >= MIN_N) begin
                        a_n    = eff;
                        clk_n  = 1'b1;
                        tick_n = 1'b1;
                    end else begin
                        state_n = IDLE;
                        a_n     = '0;
                        clk_n   = 1'b0;
                    end
                end else begin
                    cnt_n = cnt_inc;
                    clk_n = (cnt_inc < half);
                    if (div_load) begin
                        pend_n = div_val;
                        busy_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                a_n     = '0;
                cnt_n   = '0;
                pend_n  = '0;
                busy_n  = 1'b0;
                clk_n   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            a_q      <= '0;
            pend     <= '0;
            div_busy <= 1'b0;
            clk_out  <= 1'b0;
            tick     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            a_q      <= a_n;
            pend     <= pend_n;
            div_busy <= busy_n;
            clk_out  <= clk_n;
            tick     <= tick_n;
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: each task drives one scenario and checks
// {clk_out, tick, div_busy} against hand-derived expectations.
module tb_clk_div_prog;
    import clk_div_pkg::*;

    logic       clk;
    logic       rst;
    logic [7:0] div_val;
    logic       div_load;
    logic       div_busy;
    logic       clk_out;
    logic       tick;
    state_t     state_dbg;

    int n_checks;
    int n_fail;

    clk_div_prog #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .div_val   (div_val),
        .div_load  (div_load),
        .div_busy  (div_busy),
        .clk_out   (clk_out),
        .tick      (tick),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are then observed 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        div_load = 1'b0;
        div_val  = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        cyc();
    endtask

    task automatic load(input logic [7:0] v);
        div_val  = v;
        div_load = 1'b1;
        cyc();
        div_load = 1'b0;
        div_val  = '0;
    endtask

    task automatic test_reset();
        rst      = 1'b0;
        div_load = 1'b0;
        div_val  = '0;
        #3;
        n_checks++;
        if ({clk_out, tick, div_busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 000", {clk_out, tick, div_busy});
        end
        n_checks++;
        if (state_dbg !== IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got %0d expected %0d", state_dbg, IDLE);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            n_checks++;
            if ({clk_out, tick, div_busy} !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_idle cyc %0d: got %b expected 000", i, {clk_out, tick, div_busy});
            end
        end
    endtask

    // Steady run at a fixed ratio starting from the cycle right after the load.
    task automatic test_steady(input int n, input int ncyc);
        logic [2:0] e;
        do_reset();
        load(8'(n));
        for (int i = 0; i < ncyc; i++) begin
            e = {((i % n) < (n + 1) / 2), ((i % n) == 0), 1'b0};
            n_checks++;
            if ({clk_out, tick, div_busy} !== e) begin
                n_fail++;
                $display("FAIL steady_div%0d cyc %0d: got %b expected %b", n, i, {clk_out, tick, div_busy}, e);
            end
            cyc();
        end
    endtask

    task automatic test_retarget();
        logic [2:0] e;
        do_reset();
        load(8'd4);
        cyc();
        load(8'd6);
        for (int c = 2; c < 4; c++) begin
            n_checks++;
            if ({clk_out, tick, div_busy} !== 3'b001) begin
                n_fail++;
                $display("FAIL retarget_old cnt %0d: got %b expected 001", c, {clk_out, tick, div_busy});
            end
            cyc();
        end
        for (int i = 0; i < 12; i++) begin
            e = {((i % 6) < 3), ((i % 6) == 0), 1'b0};
            n_checks++;
            if ({clk_out, tick, div_busy} !== e) begin
                n_fail++;
                $display("FAIL retarget_new cyc %0d: got %b expected %b", i, {clk_out, tick, div_busy}, e);
            end
            cyc();
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] e;
        do_reset();
        load(8'd8);
        cyc();
        load(8'd3);
        n_checks++;
        if ({clk_out, tick, div_busy} !== 3'b101) begin
            n_fail++;
            $display("FAIL b2b_first_load: got %b expected 101", {clk_out, tick, div_busy});
        end
        load(8'd10);
        for (int c = 3; c < 8; c++) begin
            e = {(c < 4), 1'b0, 1'b1};
            n_checks++;
            if ({clk_out, tick, div_busy} !== e) begin
                n_fail++;
                $display("FAIL b2b_old cnt %0d: got %b expected %b", c, {clk_out, tick, div_busy}, e);
            end
            cyc();
        end
        for (int i = 0; i < 20; i++) begin
            e = {((i % 10) < 5), ((i % 10) == 0), 1'b0};
            n_checks++;
            if ({clk_out, tick, div_busy} !== e) begin
                n_fail++;
                $display("FAIL b2b_new cyc %0d: got %b expected %b", i, {clk_out, tick, div_busy}, e);
            end
            cyc();
        end
    endtask

    task automatic test_bypass();
        logic [2:0] e;
        do_reset();
        load(8'd8);
        repeat (7) cyc();
        load(8'd3);
        for (int i = 0; i < 9; i++) begin
            e = {((i % 3) < 2), ((i % 3) == 0), 1'b0};
            n_checks++;
            if ({clk_out, tick, div_busy} !== e) begin
                n_fail++;
                $display("FAIL bypass cyc %0d: got %b expected %b", i, {clk_out, tick, div_busy}, e);
            end
            cyc();
        end
    endtask

    task automatic test_disable();
        logic [2:0] e;
        do_reset();
        load(8'd6);
        cyc();
        load(8'd0);
        for (int c = 2; c < 6; c++) begin
            e = {(c < 3), 1'b0, 1'b1};
            n_checks++;
            if ({clk_out, tick, div_busy} !== e) begin
                n_fail++;
                $display("FAIL disable_tail cnt %0d: got %b expected %b", c, {clk_out, tick, div_busy}, e);
            end
            cyc();
        end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if ({clk_out, tick, div_busy, state_dbg} !== {3'b000, IDLE}) begin
                n_fail++;
                $display("FAIL disable_idle cyc %0d: got %b expected 0000", i, {clk_out, tick, div_busy, state_dbg});
            end
            cyc();
        end
        load(8'd1);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({clk_out, tick, div_busy} !== 3'b000) begin
                n_fail++;
                $display("FAIL load1_ignored cyc %0d: got %b expected 000", i, {clk_out, tick, div_busy});
            end
            cyc();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        load(8'd4);
        cyc();
        load(8'd6);
        n_checks++;
        if ({clk_out, tick, div_busy} !== 3'b001) begin
            n_fail++;
            $display("FAIL rstmid_pre: got %b expected 001", {clk_out, tick, div_busy});
        end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({clk_out, tick, div_busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL rstmid_async: got %b expected 000", {clk_out, tick, div_busy});
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            n_checks++;
            if ({clk_out, tick, div_busy} !== 3'b000) begin
                n_fail++;
                $display("FAIL rstmid_idle cyc %0d: got %b expected 000", i, {clk_out, tick, div_busy});
            end
        end
        load(8'd5);
        n_checks++;
        if ({clk_out, tick, div_busy} !== 3'b110) begin
            n_fail++;
            $display("FAIL rstmid_reload: got %b expected 110", {clk_out, tick, div_busy});
        end
        cyc();
        n_checks++;
        if ({clk_out, tick, div_busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL rstmid_reload_c1: got %b expected 100", {clk_out, tick, div_busy});
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        div_load = 1'b0;
        div_val  = '0;
        test_reset();
        test_steady(4, 16);
        test_steady(5, 15);
        test_steady(2, 6);
        test_steady(255, 520);
        test_retarget();
        test_back_to_back();
        test_bypass();
        test_disable();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
